// File: rtl/bcd7_display_ctrl_pkg.sv
// bcd7_display_ctrl_pkg: shared constants and tables for the 7-segment display controller
package bcd7_display_ctrl_pkg;
  localparam logic [31:0] DISP_ADDR_DEF = 32'h4000_0010;
  localparam logic [11:0] BCD7_BLANK = 12'hFFF;
  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_e;
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [3:0][3:0] ANODE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
endpackage

// File: rtl/bcd7_display_ctrl_if.sv
// bcd7_display_ctrl_if: CPU load/store bus toward the display register
interface bcd7_display_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  modport master (output mem_read, mem_write, addr, wdata, input rdata, rvalid);
  modport slave (input mem_read, mem_write, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/bcd7_display_ctrl_hex7seg.sv
// hex7seg: nibble to active-low {dp,g,f,e,d,c,b,a} segment code
module hex7seg
  import bcd7_display_ctrl_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_seg
);
  assign o_seg = SEG_TABLE[i_nib];
endmodule

// File: rtl/bcd7_display_ctrl.sv
// bcd7_display_ctrl: memory-mapped 4-digit multiplexed 7-segment display
module bcd7_display_ctrl
  import bcd7_display_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter logic [31:0] DISP_ADDR = DISP_ADDR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  bcd7_display_ctrl_if.slave  bus,
  output logic [11:0]         BCD7
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  logic [15:0]   r_val;
  logic          r_en;
  logic [CW-1:0] r_cnt;
  digit_e        r_digit;
  logic [31:0]   r_rdata;
  logic          r_rvalid;
  logic [11:0]   r_bcd7;
  logic          w_hit;
  logic          w_wr;
  logic          w_rd;
  logic          w_wrap;
  logic [3:0]    w_nib;
  logic [7:0]    w_seg;
  assign w_hit  = bus.addr[31:2] == DISP_ADDR[31:2];
  assign w_wr   = bus.mem_write && w_hit;
  assign w_rd   = bus.mem_read && w_hit;
  assign w_wrap = r_cnt == LAST;
  assign w_nib  = r_val[{r_digit, 2'b00} +: 4];
  hex7seg u_hex7seg (.i_nib(w_nib), .o_seg(w_seg));
  // register file, read return, digit scan and registered display output
  always_ff @(posedge clk) begin
    if (reset) begin
      r_val    <= '0;
      r_en     <= 1'b0;
      r_cnt    <= '0;
      r_digit  <= DIG0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_bcd7   <= BCD7_BLANK;
    end else begin
      if (w_wr) begin
        r_val <= bus.wdata[15:0];
        r_en  <= bus.wdata[16];
      end
      r_rvalid <= w_rd;
      r_rdata  <= w_rd ? {15'b0, r_en, r_val} : '0;
      r_cnt    <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_digit <= digit_e'(r_digit + 2'd1);
      r_bcd7   <= r_en ? {ANODE[r_digit], w_seg} : BCD7_BLANK;
    end
  end
  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign BCD7       = r_bcd7;
endmodule
